// File: rtl/debug_pkg.sv
// Shared definitions for the debugger command controller: opcodes, status codes
// and the controller state encoding.
package debug_pkg;

    localparam logic [7:0] CMD_STEP   = 8'h31;
    localparam logic [7:0] CMD_RUN    = 8'h32;
    localparam logic [7:0] CMD_RESET  = 8'h33;
    localparam logic [7:0] CMD_STEPN  = 8'h34;
    localparam logic [7:0] CMD_SETBP  = 8'h35;
    localparam logic [7:0] CMD_CLRBP  = 8'h36;

    localparam logic [7:0] STS_DONE     = 8'h00;
    localparam logic [7:0] STS_FINISHED = 8'h01;
    localparam logic [7:0] STS_BREAK    = 8'h02;
    localparam logic [7:0] STS_RESET    = 8'h03;
    localparam logic [7:0] STS_ACK      = 8'h04;
    localparam logic [7:0] STS_UNKNOWN  = 8'hFF;

    typedef enum logic [3:0] {
        S_HW_RST    = 4'd0,
        S_IDLE      = 4'd1,
        S_ARG       = 4'd2,
        S_STEP      = 4'd3,
        S_CHECK     = 4'd4,
        S_RUN_STEP  = 4'd5,
        S_RUN_CHECK = 4'd6,
        S_PRESET    = 4'd7,
        S_SEND      = 4'd8,
        S_WAIT_SENT = 4'd9
    } state_t;

endpackage

// File: rtl/debug_step_counter.sv
// Saturating executed-step counter with synchronous clear.
module debug_step_counter
    import debug_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/debug_cmd_controller.sv
// Debugger command controller: decodes UART command bytes, steps/runs/resets the
// pipeline, handles breakpoints and reports a status byte to the transmitter.
module debug_cmd_controller
    import debug_pkg::*;
#(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned STEP_W     = 8,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       r_data,
    input  logic             rx_ready,
    input  logic             data_sent,
    input  logic             program_finished,
    input  logic [PC_W-1:0]  pc_in,
    output logic             rd_uart,
    output logic             pipe_step,
    output logic             pipe_reset,
    output logic             send_signal,
    output logic [7:0]       send_code,
    output logic [CNT_W-1:0] step_count,
    output logic [3:0]       current_state
);

    localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

    state_t            r_state, w_state_nxt;
    logic              r_rd_uart, w_rd_uart_nxt;
    logic [7:0]        r_rx_byte, w_rx_byte_nxt;
    logic [7:0]        r_opcode, w_opcode_nxt;
    logic [7:0]        r_arg_lo, w_arg_lo_nxt;
    logic              r_arg_second, w_arg_second_nxt;
    logic [STEP_W-1:0] r_steps_left, w_steps_left_nxt;
    logic [PC_W-1:0]   r_bp_pc, w_bp_pc_nxt;
    logic              r_bp_valid, w_bp_valid_nxt;
    logic [7:0]        r_send_code, w_send_code_nxt;
    logic [RW-1:0]     r_rst_cnt, w_rst_cnt_nxt;
    logic              w_go_send;
    logic [7:0]        w_code;
    logic [STEP_W-1:0] w_n;
    logic              w_bp_hit;

    assign w_bp_hit = r_bp_valid && (pc_in == r_bp_pc);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_HW_RST;
            r_rd_uart    <= 1'b0;
            r_rx_byte    <= '0;
            r_opcode     <= '0;
            r_arg_lo     <= '0;
            r_arg_second <= 1'b0;
            r_steps_left <= '0;
            r_bp_pc      <= '0;
            r_bp_valid   <= 1'b0;
            r_send_code  <= '0;
            r_rst_cnt    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_uart    <= w_rd_uart_nxt;
            r_rx_byte    <= w_rx_byte_nxt;
            r_opcode     <= w_opcode_nxt;
            r_arg_lo     <= w_arg_lo_nxt;
            r_arg_second <= w_arg_second_nxt;
            r_steps_left <= w_steps_left_nxt;
            r_bp_pc      <= w_bp_pc_nxt;
            r_bp_valid   <= w_bp_valid_nxt;
            r_send_code  <= w_send_code_nxt;
            r_rst_cnt    <= w_rst_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_rd_uart_nxt    = 1'b0;
        w_rx_byte_nxt    = r_rx_byte;
        w_opcode_nxt     = r_opcode;
        w_arg_lo_nxt     = r_arg_lo;
        w_arg_second_nxt = r_arg_second;
        w_steps_left_nxt = r_steps_left;
        w_bp_pc_nxt      = r_bp_pc;
        w_bp_valid_nxt   = r_bp_valid;
        w_send_code_nxt  = r_send_code;
        w_rst_cnt_nxt    = r_rst_cnt;
        w_go_send        = 1'b0;
        w_code           = STS_DONE;
        w_n              = STEP_W'(r_rx_byte);

        case (r_state)
            S_HW_RST, S_PRESET: begin
                if (r_rst_cnt == RST_LAST) begin
                    w_rst_cnt_nxt = '0;
                    if (r_state == S_HW_RST) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_go_send = 1'b1;
                        w_code    = STS_RESET;
                    end
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt + 1'b1;
                end
            end
            // A popped byte is decoded in the cycle rd_uart is high; rx_ready is
            // ignored then because the UART may not have dropped it yet.
            S_IDLE: begin
                if (r_rd_uart) begin
                    w_opcode_nxt     = r_rx_byte;
                    w_arg_second_nxt = 1'b0;
                    case (r_rx_byte)
                        CMD_STEP: begin
                            w_steps_left_nxt = STEP_W'(1);
                            if (program_finished) begin
                                w_go_send = 1'b1;
                                w_code    = STS_FINISHED;
                            end else begin
                                w_state_nxt = S_STEP;
                            end
                        end
                        CMD_RUN: begin
                            if (program_finished) begin
                                w_go_send = 1'b1;
                                w_code    = STS_FINISHED;
                            end else begin
                                w_state_nxt = S_RUN_STEP;
                            end
                        end
                        CMD_RESET: begin
                            w_rst_cnt_nxt = '0;
                            w_state_nxt   = S_PRESET;
                        end
                        CMD_STEPN, CMD_SETBP: w_state_nxt = S_ARG;
                        CMD_CLRBP: begin
                            w_bp_valid_nxt = 1'b0;
                            w_go_send      = 1'b1;
                            w_code         = STS_ACK;
                        end
                        default: begin
                            w_go_send = 1'b1;
                            w_code    = STS_UNKNOWN;
                        end
                    endcase
                end else if (rx_ready) begin
                    w_rd_uart_nxt = 1'b1;
                    w_rx_byte_nxt = r_data;
                end
            end
            S_ARG: begin
                if (r_rd_uart) begin
                    if (r_opcode == CMD_STEPN) begin
                        w_steps_left_nxt = w_n;
                        if (w_n == '0) begin
                            w_go_send = 1'b1;
                            w_code    = STS_DONE;
                        end else if (program_finished) begin
                            w_go_send = 1'b1;
                            w_code    = STS_FINISHED;
                        end else begin
                            w_state_nxt = S_STEP;
                        end
                    end else if (!r_arg_second) begin
                        w_arg_lo_nxt     = r_rx_byte;
                        w_arg_second_nxt = 1'b1;
                    end else begin
                        w_bp_pc_nxt    = PC_W'({r_rx_byte, r_arg_lo});
                        w_bp_valid_nxt = 1'b1;
                        w_go_send      = 1'b1;
                        w_code         = STS_ACK;
                    end
                end else if (rx_ready) begin
                    w_rd_uart_nxt = 1'b1;
                    w_rx_byte_nxt = r_data;
                end
            end
            S_STEP: begin
                w_steps_left_nxt = r_steps_left - 1'b1;
                w_state_nxt      = S_CHECK;
            end
            S_CHECK, S_RUN_CHECK: begin
                if (program_finished) begin
                    w_go_send = 1'b1;
                    w_code    = STS_FINISHED;
                end else if (w_bp_hit) begin
                    w_go_send = 1'b1;
                    w_code    = STS_BREAK;
                end else if (r_state == S_RUN_CHECK) begin
                    w_state_nxt = S_RUN_STEP;
                end else if (r_steps_left == '0) begin
                    w_go_send = 1'b1;
                    w_code    = STS_DONE;
                end else begin
                    w_state_nxt = S_STEP;
                end
            end
            S_RUN_STEP:  w_state_nxt = S_RUN_CHECK;
            S_SEND:      w_state_nxt = S_WAIT_SENT;
            S_WAIT_SENT: if (data_sent) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_HW_RST;
        endcase

        if (w_go_send) begin
            w_state_nxt     = S_SEND;
            w_send_code_nxt = w_code;
        end
    end

    debug_step_counter #(.CNT_W(CNT_W)) u_step_counter (
        .clock   (clock),
        .reset   (reset),
        .i_clear (r_state == S_PRESET),
        .i_inc   (pipe_step),
        .o_count (step_count)
    );

    assign rd_uart       = r_rd_uart;
    assign pipe_step     = (r_state == S_STEP) || (r_state == S_RUN_STEP);
    assign pipe_reset    = (r_state == S_HW_RST) || (r_state == S_PRESET);
    assign send_signal   = (r_state == S_SEND);
    assign send_code     = r_send_code;
    assign current_state = r_state;

endmodule

// File: tb/tb_debug_cmd_controller.sv
// Scoreboard bench for debug_cmd_controller: expected status bytes are queued by
// the stimulus and checked by a monitor whenever send_signal is seen.
module tb_debug_cmd_controller;

    localparam int unsigned PC_W       = 10;
    localparam int unsigned STEP_W     = 8;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned RST_CYCLES = 4;
    localparam logic [3:0]  ST_HW_RST    = 4'd0;
    localparam logic [3:0]  ST_IDLE      = 4'd1;
    localparam logic [3:0]  ST_WAIT_SENT = 4'd9;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [7:0]       r_data = '0;
    logic             rx_ready = 1'b0;
    logic             data_sent = 1'b0;
    logic             program_finished;
    logic [PC_W-1:0]  pc_in;
    logic             rd_uart, pipe_step, pipe_reset, send_signal;
    logic [7:0]       send_code;
    logic [CNT_W-1:0] step_count;
    logic [3:0]       current_state;

    always #5 clock = ~clock;

    debug_cmd_controller #(
        .PC_W(PC_W), .STEP_W(STEP_W), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clock(clock), .reset(reset), .r_data(r_data), .rx_ready(rx_ready),
        .data_sent(data_sent), .program_finished(program_finished), .pc_in(pc_in),
        .rd_uart(rd_uart), .pipe_step(pipe_step), .pipe_reset(pipe_reset),
        .send_signal(send_signal), .send_code(send_code), .step_count(step_count),
        .current_state(current_state)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    int cyc = 0, t_rd = 0, t_ps = 0, t_ss = 0;
    int n_steps = 0, n_pops = 0, pr_cycles = 0;

    // Pipeline model: PC advances by 4 per step; finish flag after fin_after steps.
    logic            pc_clear = 1'b0;
    logic            force_fin = 1'b0;
    int              fin_after = 0;
    int              fin_cnt = 0;
    logic [PC_W-1:0] pc_q = '0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (pc_clear) begin
            pc_q    <= '0;
            fin_cnt <= 0;
        end else if (pipe_step) begin
            pc_q    <= pc_q + PC_W'(4);
            fin_cnt <= fin_cnt + 1;
        end
    end

    assign pc_in = pc_q;
    assign program_finished = force_fin | ((fin_after != 0) && (fin_cnt >= fin_after));

    always @(negedge clock) begin
        logic [7:0] e;
        if (rd_uart) begin
            t_rd = cyc;
            n_pops++;
        end
        if (pipe_step) begin
            t_ps = cyc;
            n_steps++;
        end
        if (pipe_reset) pr_cycles++;
        if (send_signal) begin
            t_ss = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_send: send_code=%02h but no status expected", send_code);
            end else begin
                e = exp_q.pop_front();
                if (send_code !== e) begin
                    failures++;
                    $display("FAIL send_code: got %02h expected %02h", send_code, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clock);
        r_data   = b;
        rx_ready = 1'b1;
        do begin
            @(negedge clock);
            n++;
        end while (!rd_uart && n < 20);
        check("rd_uart_pop", {31'd0, rd_uart}, 32'd1);
        rx_ready = 1'b0;
    endtask

    task automatic wait_send();
        int n = 0;
        while (!send_signal && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (!send_signal) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: no send_signal within %0d cycles", n);
        end else begin
            data_sent = 1'b1;
            @(negedge clock);
            check("data_sent_ignored_in_send", {28'd0, current_state}, {28'd0, ST_WAIT_SENT});
            @(negedge clock);
            check("idle_after_data_sent", {28'd0, current_state}, {28'd0, ST_IDLE});
            data_sent = 1'b0;
        end
    endtask

    task automatic cmd(input logic [7:0] b0, input int nb, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] exp);
        exp_q.push_back(exp);
        put_byte(b0);
        if (nb > 1) put_byte(b1);
        if (nb > 2) put_byte(b2);
        wait_send();
    endtask

    task automatic clear_pc();
        @(negedge clock);
        pc_clear = 1'b1;
        @(negedge clock);
        pc_clear = 1'b0;
    endtask

    task automatic release_reset();
        int pr = 0;
        @(posedge clock);
        #1 reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (pipe_reset) pr++;
            else break;
        end
        check("hw_reset_len", pr, RST_CYCLES);
        check("idle_after_hw_reset", {28'd0, current_state}, {28'd0, ST_IDLE});
    endtask

    initial begin
        int s0, p0;
        repeat (3) @(negedge clock);
        check("rst_rd_uart", {31'd0, rd_uart}, 32'd0);
        check("rst_pipe_step", {31'd0, pipe_step}, 32'd0);
        check("rst_pipe_reset", {31'd0, pipe_reset}, 32'd1);
        check("rst_send_signal", {31'd0, send_signal}, 32'd0);
        check("rst_send_code", {24'd0, send_code}, 32'd0);
        check("rst_step_count", {16'd0, step_count}, 32'd0);
        check("rst_state", {28'd0, current_state}, {28'd0, ST_HW_RST});
        release_reset();

        // Single steps with latency check on the first one
        s0 = n_steps;
        cmd(8'h31, 1, 8'h00, 8'h00, 8'h00);
        check("step1_rd_to_pipe_step", t_ps - t_rd, 1);
        check("step1_rd_to_send", t_ss - t_rd, 3);
        cmd(8'h31, 1, 8'h00, 8'h00, 8'h00);
        cmd(8'h31, 1, 8'h00, 8'h00, 8'h00);
        check("three_steps", n_steps - s0, 3);
        check("step_count_3", {16'd0, step_count}, 32'd3);

        // Breakpoint at PC 8, run from PC 0
        cmd(8'h35, 3, 8'h08, 8'h00, 8'h04);
        clear_pc();
        s0 = n_steps;
        cmd(8'h32, 1, 8'h00, 8'h00, 8'h02);
        check("run_steps_to_bp", n_steps - s0, 2);
        check("run_pc_at_bp", {22'd0, pc_in}, 32'd8);
        check("step_count_5", {16'd0, step_count}, 32'd5);

        // Step 5 with finish after 2nd step; bp also hits at PC 8, finish wins
        clear_pc();
        fin_after = 2;
        s0 = n_steps;
        cmd(8'h34, 2, 8'h05, 8'h00, 8'h01);
        check("stepn_finished_steps", n_steps - s0, 2);
        fin_after = 0;

        // Clear breakpoint, then step 3 passes PC 8 freely
        cmd(8'h36, 1, 8'h00, 8'h00, 8'h04);
        clear_pc();
        s0 = n_steps;
        cmd(8'h34, 2, 8'h03, 8'h00, 8'h00);
        check("stepn3_steps", n_steps - s0, 3);
        check("stepn3_pc", {22'd0, pc_in}, 32'd12);
        s0 = n_steps;
        cmd(8'h34, 2, 8'h00, 8'h00, 8'h00);
        check("stepn0_no_step", n_steps - s0, 0);

        // Entry check with program already finished
        force_fin = 1'b1;
        s0 = n_steps;
        cmd(8'h31, 1, 8'h00, 8'h00, 8'h01);
        cmd(8'h32, 1, 8'h00, 8'h00, 8'h01);
        check("finished_entry_no_step", n_steps - s0, 0);
        force_fin = 1'b0;
        check("step_count_10", {16'd0, step_count}, 32'd10);

        // Software reset and unknown opcode
        pr_cycles = 0;
        cmd(8'h33, 1, 8'h00, 8'h00, 8'h03);
        check("preset_len", pr_cycles, RST_CYCLES);
        check("preset_step_count", {16'd0, step_count}, 32'd0);
        cmd(8'h41, 1, 8'h00, 8'h00, 8'hFF);

        // Unbounded run (bp cleared), bytes ignored while running, then hard reset
        clear_pc();
        s0 = n_steps;
        put_byte(8'h32);
        repeat (6) @(negedge clock);
        check("run_active", {31'd0, (n_steps > s0)}, 32'd1);
        p0 = n_pops;
        r_data = 8'h41;
        rx_ready = 1'b1;
        repeat (6) @(negedge clock);
        rx_ready = 1'b0;
        check("rx_ignored_while_running", n_pops - p0, 0);
        reset = 1'b0;
        #1;
        check("midrun_rst_pipe_reset", {31'd0, pipe_reset}, 32'd1);
        check("midrun_rst_pipe_step", {31'd0, pipe_step}, 32'd0);
        check("midrun_rst_send_signal", {31'd0, send_signal}, 32'd0);
        check("midrun_rst_step_count", {16'd0, step_count}, 32'd0);
        check("midrun_rst_state", {28'd0, current_state}, {28'd0, ST_HW_RST});
        repeat (3) @(negedge clock);
        release_reset();
        clear_pc();
        cmd(8'h31, 1, 8'h00, 8'h00, 8'h00);
        check("post_reset_step_count", {16'd0, step_count}, 32'd1);

        repeat (4) @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/debug_cmd_controller.md
# debug_cmd_controller

Parametrised successor to the debugger's UART command receiver. Decodes command bytes from the UART receiver and drives the MIPS pipeline through a clock-enable step strobe and a synchronous pipeline reset. Adds N-step, run-to-breakpoint, breakpoint set/clear, a step counter and a status byte for the debugger transmitter. Sits between the UART (rx side), the pipeline/end-of-program detector and the debugger transmitter.

## Interface
- PC_W, 10, pipeline PC width (≤16)
- STEP_W, 8, N-step argument and counter width
- CNT_W, 16, executed-step counter width
- RST_CYCLES, 4, cycles pipe_reset is held after any reset request (≥1)
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- r_data  in  8  UART received byte
- rx_ready  in  1  UART byte available (level)
- data_sent  in  1  transmitter finished sending status
- program_finished  in  1  end-of-program detector flag
- pc_in  in  PC_W  current IF/ID PC
- rd_uart  out  1  one-cycle pop of UART byte
- pipe_step  out  1  one-cycle pipeline clock enable
- pipe_reset  out  1  pipeline synchronous reset
- send_signal  out  1  one-cycle request to transmitter
- send_code  out  8  status byte, valid while send_signal/WAIT_SENT
- step_count  out  CNT_W  steps executed since last reset
- current_state  out  4  FSM state encoding, for debug

## Operation
- Commands (ASCII): 0x31 step 1; 0x32 run; 0x33 software reset; 0x34 step N (one argument byte N); 0x35 set breakpoint (two argument bytes, low then high, truncated to PC_W); 0x36 clear breakpoint; other bytes → unknown.
- States: HW_RST, IDLE, ARG, STEP, CHECK, RUN_STEP, RUN_CHECK, PRESET, SEND, WAIT_SENT.
- HW_RST: entered on reset; pipe_reset=1 for RST_CYCLES cycles after reset release, then IDLE; no status sent.
- IDLE: on rx_ready, pulse rd_uart, latch opcode; 0x34/0x35 → ARG; 0x31 → STEP with steps_left=1; 0x32 → RUN_STEP; 0x33 → PRESET; 0x36 clears bp_valid → SEND code 0x04; unknown → SEND code 0xFF.
- ARG: each rx_ready pops one byte (rd_uart pulse); after last argument: 0x34 → STEP with steps_left=N (N=0 → SEND 0x00, no step); 0x35 loads bp_pc, sets bp_valid → SEND 0x04.
- STEP: pipe_step=1 one cycle, steps_left−1, → CHECK. CHECK: program_finished → SEND 0x01; bp_valid and pc_in==bp_pc → SEND 0x02; steps_left==0 → SEND 0x00; else STEP.
- RUN_STEP/RUN_CHECK: same alternation, unbounded, exits only on finished (0x01) or breakpoint (0x02).
- Entry check: step or run with program_finished already 1 → SEND 0x01 without stepping.
- PRESET: pipe_reset=1 RST_CYCLES cycles, step_count cleared → SEND 0x03. Breakpoint retained.
- SEND: send_signal=1 one cycle → WAIT_SENT; on data_sent → IDLE.
- step_count increments on each pipe_step, saturates at all-ones.
- rx_ready outside IDLE/ARG: ignored, byte not popped.

## Timing
- Reset values: rd_uart 0, pipe_step 0, pipe_reset 1, send_signal 0, send_code 0x00, step_count 0, bp_valid 0, state HW_RST.
- rd_uart asserted in the cycle after rx_ready is sampled in IDLE/ARG; rx_ready must drop within one cycle of rd_uart.
- Each step = 2 cycles (STEP + CHECK); pc_in/program_finished sampled in CHECK, one cycle after pipe_step.
- Step 1: byte accepted at t → rd_uart t+1, pipe_step t+2, send_signal t+4.
- data_sent seen in the same cycle as send_signal is ignored; WAIT_SENT holds until data_sent.
- Finished and breakpoint true in same CHECK: code 0x01 wins.
- Asynchronous reset at any time aborts the command, no status is sent, HW_RST re-entered.

## Structure
- Shared package debug_pkg: command opcodes, status codes, state enumeration.
- One sub-module natural: debug_step_counter (saturating CNT_W counter with clear/inc).

## Test plan
- Reset released → pipe_reset high exactly 4 cycles, then IDLE, no send_signal.
- 0x31 three times, data_sent after each → 3 pipe_step pulses, three send_code 0x00, step_count=3.
- 0x35,0x08,0x00 then 0x32 with PC incrementing by 4 → ack 0x04; run stops after PC reaches 8, send_code 0x02.
- 0x34,0x05 with program_finished rising after 2nd step → exactly 2 pipe_step, send_code 0x01.
- 0x33 after steps → pipe_reset 4 cycles, step_count=0, send_code 0x03; 0x41 → send_code 0xFF.
- Reset asserted mid-run → outputs return to reset values immediately, no send_signal.
